// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge/response sequencer.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FIRE,
    SETTLE,
    CAPTURE,
    OUT
  } puf_state_e;

  localparam int PUF_N = 128;

  // x^128 + x^126 + x^101 + x^99 + 1 : taps at bits 127, 125, 100, 98
  localparam logic [PUF_N-1:0] LFSR_TAPS_DEFAULT = 128'hA000_0014_0000_0000_0000_0000_0000_0000;

  localparam int VOTE_COUNT = 3;

endpackage

// File: rtl/puf_crp_sequencer_if.sv
// Valid/ready stream carrying challenge/response pairs to enrollment/authentication logic.
interface puf_crp_sequencer_if
  import puf_pkg::*;
#(
  parameter int N = PUF_N
);
  logic         crp_valid;
  logic         crp_ready;
  logic [N-1:0] crp_challenge;
  logic [N-1:0] crp_response;

  modport master (output crp_valid, crp_challenge, crp_response, input crp_ready);
  modport slave  (input crp_valid, crp_challenge, crp_response, output crp_ready);
endinterface

// File: rtl/puf_lfsr.sv
// N-bit Fibonacci LFSR challenge generator with seed load and zero-seed substitution.
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int           N    = PUF_N,
  parameter logic [N-1:0] TAPS = N'(LFSR_TAPS_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         step,
  output logic [N-1:0] value
);

  logic [N-1:0] lfsr_q;

  // All-zero is the lockup state, so a zero seed becomes 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= N'(1);
    end else if (load) begin
      lfsr_q <= (seed == '0) ? N'(1) : seed;
    end else if (step) begin
      lfsr_q <= {lfsr_q[N-2:0], ^(lfsr_q & TAPS)};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/puf_crp_sequencer.sv
// Drives the arbiter-PUF array with LFSR challenges and streams out captured CRPs.
// Define PUF_VOTE_EN to evaluate each challenge three times and emit the bitwise majority.
module puf_crp_sequencer
  import puf_pkg::*;
#(
  parameter int           N             = PUF_N,
  parameter int           SETTLE_CYCLES = 4,
  parameter logic [N-1:0] LFSR_TAPS     = N'(LFSR_TAPS_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         num_crps,
  input  logic                seed_load,
  input  logic [N-1:0]        seed,
  output logic [N-1:0]        puf_challenge,
  output logic                puf_signal,
  input  logic [N-1:0]        puf_response,
  puf_crp_sequencer_if.master crp,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(SETTLE_CYCLES);

  puf_state_e    state, next_state;
  logic [15:0]   remaining;
  logic [CW-1:0] settle_cnt;
  logic [N-1:0]  lfsr_val;
  logic [N-1:0]  chal_q;
  logic [N-1:0]  resp_q;
  logic          done_q;
  logic          handshake;
  logic          lfsr_load;
  logic          last_eval;

  assign handshake = (state == OUT) && crp.crp_ready;
  assign lfsr_load = (state == IDLE) && seed_load;

  puf_lfsr #(.N(N), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (handshake),
    .value (lfsr_val)
  );

`ifdef PUF_VOTE_EN
  logic [1:0]   vote_idx;
  logic [N-1:0] cap0, cap1;

  assign last_eval = (vote_idx == 2'(VOTE_COUNT - 1));

  function automatic logic [N-1:0] majority3(input logic [N-1:0] a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`else
  assign last_eval = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start && (num_crps != 16'd0)) next_state = ARM;
      ARM:     next_state = FIRE;
      FIRE:    next_state = SETTLE;
      SETTLE:  if (settle_cnt == '0) next_state = CAPTURE;
      CAPTURE: next_state = last_eval ? OUT : ARM;
      OUT:     if (crp.crp_ready) next_state = (remaining == 16'd1) ? IDLE : ARM;
      default: next_state = IDLE;
    endcase
  end

  // Run bookkeeping: CRP count, settle timer, end-of-run pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining  <= '0;
      settle_cnt <= '0;
      done_q     <= 1'b0;
`ifdef PUF_VOTE_EN
      vote_idx   <= '0;
`endif
    end else begin
      if ((state == IDLE) && start) remaining <= num_crps;
      else if (handshake)           remaining <= remaining - 16'd1;

      if (state == FIRE)                          settle_cnt <= CW'(SETTLE_CYCLES - 1);
      else if ((state == SETTLE) && (settle_cnt != '0)) settle_cnt <= settle_cnt - 1'b1;

      done_q <= ((state == IDLE) && start && (num_crps == 16'd0)) ||
                (handshake && (remaining == 16'd1));
`ifdef PUF_VOTE_EN
      if (state == CAPTURE) vote_idx <= last_eval ? 2'd0 : vote_idx + 2'd1;
`endif
    end
  end

  // Capture stage: latch the PUF response against the challenge that produced it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chal_q <= '0;
      resp_q <= '0;
`ifdef PUF_VOTE_EN
      cap0   <= '0;
      cap1   <= '0;
`endif
    end else if (state == CAPTURE) begin
      chal_q <= lfsr_val;
`ifdef PUF_VOTE_EN
      if (vote_idx == 2'd0) cap0 <= puf_response;
      if (vote_idx == 2'd1) cap1 <= puf_response;
      if (last_eval)        resp_q <= majority3(cap0, cap1, puf_response);
`else
      resp_q <= puf_response;
`endif
    end
  end

  assign puf_challenge     = (state == IDLE) ? '0 : lfsr_val;
  assign puf_signal        = (state == FIRE) || (state == SETTLE) ||
                             (state == CAPTURE) || (state == OUT);
  assign busy              = (state != IDLE);
  assign done              = done_q;
  assign crp.crp_valid     = (state == OUT);
  assign crp.crp_challenge = chal_q;
  assign crp.crp_response  = resp_q;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Randomised bench for puf_crp_sequencer against a behavioural PUF and challenge-sequence model.
module tb_puf_crp_sequencer;

  localparam int           N      = 128;
  localparam int           SETTLE = 4;
  localparam logic [N-1:0] MASK   = {16{8'hA5}};
`ifdef PUF_VOTE_EN
  localparam int PERIOD = 3 * (SETTLE + 3) + 1;
`else
  localparam int PERIOD = SETTLE + 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         seed_load = 1'b0;
  logic [15:0]  num_crps = '0;
  logic [N-1:0] seed = '0;
  logic [N-1:0] puf_challenge;
  logic [N-1:0] puf_response;
  logic         puf_signal, busy, done;

  puf_crp_sequencer_if #(.N(N)) crp_if ();

  puf_crp_sequencer #(.N(N), .SETTLE_CYCLES(SETTLE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_crps      (num_crps),
    .seed_load     (seed_load),
    .seed          (seed),
    .puf_challenge (puf_challenge),
    .puf_signal    (puf_signal),
    .puf_response  (puf_response),
    .crp           (crp_if),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // PUF array model: registered response = challenge ^ MASK; vote builds corrupt bit 0 on the 2nd evaluation
  logic sig_d;
  int   fires;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_d <= 1'b0;
      fires <= 0;
      puf_response <= '0;
    end else begin
      sig_d <= puf_signal;
      if (puf_signal && !sig_d) fires <= fires + 1;
`ifdef PUF_VOTE_EN
      puf_response <= puf_challenge ^ MASK ^ N'(fires % 3 == 2);
`else
      puf_response <= puf_challenge ^ MASK;
`endif
    end
  end

  int checks = 0;
  int errors = 0;

  logic [N-1:0] model;
  logic [N-1:0] exp_ch[$];
  logic [N-1:0] obs_ch[$];
  logic [N-1:0] obs_rsp[$];
  int done_pulses, done_gap, busy_at_done, stall_viol, hi_run, hs_gap, valid_cycles;
  bit timed_out;

  function automatic logic [N-1:0] ref_next(input logic [N-1:0] v);
    return {v[N-2:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
  endfunction

  function automatic void build_expected(input int n);
    exp_ch.delete();
    for (int i = 0; i < n; i++) begin
      exp_ch.push_back(model);
      model = ref_next(model);
    end
  endfunction

  task automatic start_run(input bit do_seed, input logic [N-1:0] s, input int n);
    @(negedge clk);
    seed_load = do_seed;
    seed      = s;
    num_crps  = 16'(n);
    start     = 1'b1;
    if (do_seed) model = (s == '0) ? N'(1) : s;
    @(negedge clk);
    start     = 1'b0;
    seed_load = 1'b0;
    seed      = {4{$urandom}};
    num_crps  = 16'($urandom);
  endtask

  // Runs until done, recording handshakes, stall stability and timing; drives noise on start/seed while busy
  task automatic collect(input int stall_pct, input bit junk, input int budget);
    int cyc = 0, last_hs = -1, hi = 0;
    bit seen = 0, pv = 0, pr = 0, first_valid = 0;
    logic [N-1:0] pch = '0, prsp = '0;
    obs_ch.delete(); obs_rsp.delete();
    done_pulses = 0; done_gap = -1; busy_at_done = 0; stall_viol = 0;
    hi_run = -1; hs_gap = -1; valid_cycles = 0;
    while (!seen && cyc < budget) begin
      if (done) begin
        done_pulses++;
        done_gap = (last_hs >= 0) ? cyc - last_hs : -1;
        if (busy) busy_at_done++;
        seen = 1;
      end
      if (pv && !pr && (crp_if.crp_valid !== 1'b1 || crp_if.crp_challenge !== pch ||
                        crp_if.crp_response !== prsp)) stall_viol++;
      if (puf_signal && !crp_if.crp_valid) hi++;
      else if (!puf_signal) hi = 0;
      if (crp_if.crp_valid && !first_valid) begin
        hi_run = hi;
        first_valid = 1;
      end
      if (crp_if.crp_valid) valid_cycles++;
      crp_if.crp_ready = ($urandom_range(99) >= stall_pct);
      if (crp_if.crp_valid && crp_if.crp_ready) begin
        obs_ch.push_back(crp_if.crp_challenge);
        obs_rsp.push_back(crp_if.crp_response);
        if (last_hs >= 0) hs_gap = cyc - last_hs;
        last_hs = cyc;
      end
      if (junk && busy && !seen) begin
        start = 1'($urandom); seed_load = 1'($urandom);
        seed = {4{$urandom}}; num_crps = 16'($urandom);
      end else begin
        start = 1'b0; seed_load = 1'b0;
      end
      pv = crp_if.crp_valid; pr = crp_if.crp_ready;
      pch = crp_if.crp_challenge; prsp = crp_if.crp_response;
      @(negedge clk);
      cyc++;
    end
    timed_out = !seen;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (puf_challenge !== '0) begin errors++; $display("FAIL reset_challenge got %h want 0", puf_challenge); end
    checks++; if ({puf_signal, crp_if.crp_valid, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {puf_signal, crp_if.crp_valid, busy, done}); end
    checks++; if (crp_if.crp_challenge !== '0 || crp_if.crp_response !== '0) begin errors++; $display("FAIL reset_crp got %h/%h want 0", crp_if.crp_challenge, crp_if.crp_response); end
    @(negedge clk);
    rst_n = 1'b1;
    model = N'(1);
  endtask

  task automatic test_basic_sequence();
    logic [N-1:0] want[3];
    want[0] = N'(1); want[1] = N'(2); want[2] = N'(4);
    start_run(1'b1, N'(1), 3);
    build_expected(3);
    collect(0, 1'b0, 200);
    checks++; if (timed_out || obs_ch.size() != 3) begin errors++; $display("FAIL basic_count got %0d timeout %0d want 3", obs_ch.size(), timed_out); end
    for (int i = 0; i < 3 && i < obs_ch.size(); i++) begin
      checks++; if (obs_ch[i] !== want[i]) begin errors++; $display("FAIL basic_chal[%0d] got %h want %h", i, obs_ch[i], want[i]); end
    end
    checks++; if (done_gap != 1 || busy_at_done != 0) begin errors++; $display("FAIL basic_done gap %0d busy %0d want 1/0", done_gap, busy_at_done); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_pulse done %b busy %b want 0/0", done, busy); end
  endtask

  task automatic test_response_settle();
    start_run(1'b1, N'(128'h1234), 1);
    build_expected(1);
    collect(0, 1'b0, 200);
    checks++; if (timed_out || obs_rsp.size() != 1 || obs_rsp[0] !== (N'(128'h1234) ^ MASK) || obs_ch[0] !== N'(128'h1234)) begin
      errors++; $display("FAIL resp_value got %0d items timeout %0d want chal 1234 resp %h", obs_rsp.size(), timed_out, N'(128'h1234) ^ MASK);
    end
    // FIRE + SETTLE_CYCLES settle cycles before capture, plus the capture cycle itself
    checks++; if (hi_run != SETTLE + 2) begin errors++; $display("FAIL settle_len got %0d want %0d", hi_run, SETTLE + 2); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] s, cch, crsp;
    int bad = 0, w = 0;
    s = {4{$urandom}} | N'(1);
    crp_if.crp_ready = 1'b0;
    start_run(1'b1, s, 1);
    build_expected(1);
    while (!crp_if.crp_valid && w < 100) begin @(negedge clk); w++; end
    checks++; if (!crp_if.crp_valid) begin errors++; $display("FAIL bp_valid_timeout got 0 want 1"); end
    cch = crp_if.crp_challenge; crsp = crp_if.crp_response;
    checks++; if (cch !== exp_ch[0] || crsp !== (exp_ch[0] ^ MASK)) begin errors++; $display("FAIL bp_crp got %h want %h", cch, exp_ch[0]); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (crp_if.crp_valid !== 1'b1 || crp_if.crp_challenge !== cch || crp_if.crp_response !== crsp || done) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stall got %0d unstable cycles want 0", bad); end
    crp_if.crp_ready = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b1 || crp_if.crp_valid !== 1'b0) begin errors++; $display("FAIL bp_release done %b valid %b want 1/0", done, crp_if.crp_valid); end
    // Next run continues the sequence: the LFSR stepped exactly once for the stalled CRP
    start_run(1'b0, '0, 2);
    build_expected(2);
    collect(0, 1'b0, 200);
    checks++; if (timed_out || obs_ch.size() != 2 || obs_ch[0] !== exp_ch[0] || obs_ch[1] !== exp_ch[1]) begin
      errors++; $display("FAIL bp_continue got %0d items first %h want %h", obs_ch.size(), (obs_ch.size() > 0) ? obs_ch[0] : '0, exp_ch[0]);
    end
  endtask

  task automatic test_zero_cases();
    start_run(1'b0, '0, 0);
    collect(0, 1'b0, 20);
    checks++; if (timed_out || valid_cycles != 0 || done_pulses != 1) begin errors++; $display("FAIL zero_count valid %0d done %0d timeout %0d want 0/1/0", valid_cycles, done_pulses, timed_out); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_pulse done %b busy %b want 0/0", done, busy); end
    start_run(1'b1, '0, 1);
    build_expected(1);
    collect(0, 1'b0, 200);
    checks++; if (timed_out || obs_ch.size() != 1 || obs_ch[0] !== N'(1)) begin errors++; $display("FAIL zero_seed got %h want 1", (obs_ch.size() > 0) ? obs_ch[0] : '0); end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 6; r++) begin
      bit do_seed;
      logic [N-1:0] s;
      int n, stall;
      do_seed = (r == 0) || 1'($urandom);
      s = (r == 3) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      n = $urandom_range(1, 5);
      stall = $urandom_range(0, 60);
      start_run(do_seed, s, n);
      build_expected(n);
      collect(stall, 1'b1, 3000);
      checks++; if (timed_out || obs_ch.size() != n || done_pulses != 1) begin errors++; $display("FAIL rand%0d_count got %0d done %0d want %0d/1", r, obs_ch.size(), done_pulses, n); end
      for (int i = 0; i < n && i < obs_ch.size(); i++) begin
        checks++; if (obs_ch[i] !== exp_ch[i] || obs_rsp[i] !== (exp_ch[i] ^ MASK)) begin
          errors++; $display("FAIL rand%0d_crp[%0d] got %h/%h want %h/%h", r, i, obs_ch[i], obs_rsp[i], exp_ch[i], exp_ch[i] ^ MASK);
        end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand%0d_stall got %0d violations want 0", r, stall_viol); end
    end
  endtask

  task automatic test_throughput();
    start_run(1'b0, '0, 3);
    build_expected(3);
    collect(0, 1'b0, 500);
    checks++; if (timed_out || hs_gap != PERIOD) begin errors++; $display("FAIL throughput got %0d want %0d", hs_gap, PERIOD); end
  endtask

  task automatic test_reset_midrun();
    int rises = 0, w = 0, stray = 0;
    bit prev = 0;
    crp_if.crp_ready = 1'b1;
    start_run(1'b1, {4{$urandom}} | N'(2), 5);
    while (rises < 2 && w < 300) begin
      if (puf_signal && !prev) rises++;
      prev = puf_signal;
      if (rises < 2) begin @(negedge clk); w++; end
    end
    checks++; if (rises != 2) begin errors++; $display("FAIL midrun_wait got %0d launches want 2", rises); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({puf_signal, crp_if.crp_valid, busy} !== 3'b000) begin errors++; $display("FAIL midrun_async got %b want 000", {puf_signal, crp_if.crp_valid, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    model = N'(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrun_nodone got %0d stray cycles want 0", stray); end
    start_run(1'b0, '0, 2);
    build_expected(2);
    collect(0, 1'b0, 300);
    checks++; if (timed_out || obs_ch.size() != 2 || obs_ch[0] !== N'(1) || obs_ch[1] !== N'(2)) begin
      errors++; $display("FAIL midrun_restart got %0d items first %h want 1,2", obs_ch.size(), (obs_ch.size() > 0) ? obs_ch[0] : '0);
    end
  endtask

`ifdef PUF_VOTE_EN
  task automatic test_vote();
    int f0;
    crp_if.crp_ready = 1'b1;
    start_run(1'b1, {4{$urandom}}, 2);
    f0 = fires;
    build_expected(2);
    collect(30, 1'b0, 1000);
    checks++; if (timed_out || fires - f0 != 6) begin errors++; $display("FAIL vote_fires got %0d want 6", fires - f0); end
    for (int i = 0; i < 2 && i < obs_rsp.size(); i++) begin
      checks++; if (obs_rsp[i] !== (exp_ch[i] ^ MASK)) begin errors++; $display("FAIL vote_resp[%0d] got %h want %h", i, obs_rsp[i], exp_ch[i] ^ MASK); end
    end
  endtask
`endif

  initial begin
    crp_if.crp_ready = 1'b0;
    test_reset();
    test_basic_sequence();
    test_response_settle();
    test_backpressure();
    test_zero_cases();
    test_random_runs();
    test_throughput();
    test_reset_midrun();
`ifdef PUF_VOTE_EN
    test_vote();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
